// File: rtl/dmem_bridge_if.sv
// Core-side and memory-side buses of the data-memory bridge.
// On the core bus the bridge is the slave; on the memory bus it is the master.
interface dmem_core_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_done;
  logic        core_err;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall, core_done, core_err
  );
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall, core_done, core_err
  );
endinterface

interface dmem_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Bridges a stalling core load/store port onto a valid/ready word-addressed memory bus.
// Optional DMEM_TIMEOUT_EN aborts ISSUE/WAIT after TIMEOUT cycles with an error pulse.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  dmem_core_if.slave core,
  dmem_mem_if.master mem
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                we_q;
  logic [29:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                misaligned;
  logic                timeout_hit;

  assign misaligned = (core.core_addr[1:0] != 2'b00);

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Fires on the TIMEOUT-th ISSUE/WAIT cycle; a completion in that same cycle still wins.
  assign timeout_hit = (to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      to_cnt <= '0;
    else if (state != ISSUE && state_nxt == ISSUE)
      to_cnt <= '0;
    else if (state == ISSUE || state == WAIT)
      to_cnt <= to_cnt + 8'd1;
  end
`else
  // Unbounded waits; TIMEOUT is never 0, so this stays low.
  assign timeout_hit = (TIMEOUT == 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (core.core_req) state_nxt = misaligned ? DONE : ISSUE;
      ISSUE: begin
        if (mem.mem_ready)    state_nxt = we_q ? DONE : WAIT;
        else if (timeout_hit) state_nxt = DONE;
      end
      WAIT:  if (mem.mem_rvalid || timeout_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and response/error bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core.core_req) begin
            err_q <= misaligned;
            if (misaligned) begin
              rdata_q <= '0;
            end else begin
              we_q    <= core.core_we;
              addr_q  <= core.core_addr[31:2];
              wdata_q <= core.core_wdata;
            end
          end
        end
        ISSUE: begin
          if (!mem.mem_ready && timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            rdata_q <= mem.mem_rdata;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem.mem_valid   = (state == ISSUE);
    mem.mem_we      = (state == ISSUE) && we_q;
    mem.mem_addr    = addr_q;
    mem.mem_wdata   = wdata_q;
    core.core_done  = (state == DONE);
    core.core_err   = (state == DONE) && err_q;
    core.core_stall = core.core_req && (state != DONE);
    core.core_rdata = rdata_q;
  end

endmodule
